alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Operand/result bundle for alu_seq. The master side issues operations and the
// slave side (the ALU) returns busy/done, the result and the flags.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       op;
    logic             cin;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] rs_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d_out;
    logic             flag_z;
    logic             flag_c;

    modport master (
        output start, op, cin, rd_data, rs_data,
        input  busy, done, d_out, flag_z, flag_c
    );

    modport slave (
        input  start, op, cin, rd_data, rs_data,
        output busy, done, d_out, flag_z, flag_c
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Single-cycle add/sub/mov/lsr/dec/pass operations and
// an optional WIDTH-cycle shift-add multiplier. Results and flags are
// registered and held until the next done pulse.
// Build option: define ALU_SEQ_MUL_EN to include the multiplier (MUL state,
// busy, counter). Without it, op 101 behaves as a pass of rd_data.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    // Reject parameter combinations the counter or datapath cannot support.
    if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt_w
        $error("alu_seq: CNT_W too small for WIDTH");
    end
    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("alu_seq: WIDTH must be within 4..32");
    end

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_LSR = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b100;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b101;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
        S_MUL  = 2'd1,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic             done_q;
    logic [WIDTH-1:0] d_out_q;
    logic             flag_z_q;
    logic             flag_c_q;

    // {carry, result} of the single-cycle operation selected by op.
    logic [WIDTH:0]   alu_res;

    // Single-cycle datapath; carry is bit WIDTH of a (WIDTH+1)-bit sum.
    always_comb begin
        alu_res = {1'b0, bus.rd_data};
        case (bus.op)
            OP_ADD:  alu_res = {1'b0, bus.rd_data} + {1'b0, bus.rs_data};
            OP_SUB:  alu_res = {1'b0, bus.rd_data} + {1'b0, ~bus.rs_data} + (WIDTH+1)'(1);
            OP_MOV:  alu_res = {1'b0, bus.rs_data} + (WIDTH+1)'(bus.cin);
            OP_LSR:  alu_res = {bus.rs_data[0], 1'b0, bus.rs_data[WIDTH-1:1]};
            OP_DEC:  alu_res = {1'b0, bus.rs_data} + {1'b0, {WIDTH{1'b1}}};
            default: alu_res = {1'b0, bus.rd_data};
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic                 busy_q;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 last_bit;

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    always_comb begin
        acc_next = mplier[0] ? (acc + mcand) : acc;
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    assign bus.busy = busy_q;
`else
    assign bus.busy = 1'b0;
`endif

    assign bus.done   = done_q;
    assign bus.d_out  = d_out_q;
    assign bus.flag_z = flag_z_q;
    assign bus.flag_c = flag_c_q;

    // Control FSM with registered done/result/flags; start is only honoured outside MUL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            done_q   <= 1'b0;
            d_out_q  <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            busy_q   <= 1'b0;
            cnt      <= '0;
            mplier   <= '0;
            mcand    <= '0;
            acc      <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values;
            // done defaults low here and is re-raised only on a completing edge.
            done_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            if (state == S_MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
                if (last_bit) begin
                    state    <= S_DONE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    d_out_q  <= acc_next[WIDTH-1:0];
                    flag_z_q <= (acc_next[WIDTH-1:0] == '0);
                    flag_c_q <= |acc_next[2*WIDTH-1:WIDTH];
                end
            end else if (bus.start && bus.op == OP_MUL) begin
                state  <= S_MUL;
                busy_q <= 1'b1;
                cnt    <= '0;
                acc    <= '0;
                mplier <= bus.rd_data;
                mcand  <= {{WIDTH{1'b0}}, bus.rs_data};
            end else
`endif
            if (bus.start) begin
                state    <= S_DONE;
                done_q   <= 1'b1;
                d_out_q  <= alu_res[WIDTH-1:0];
                flag_z_q <= (alu_res[WIDTH-1:0] == '0);
                flag_c_q <= alu_res[WIDTH];
            end else if (state == S_DONE) begin
                state <= S_IDLE;
            end
        end
    end

endmodule
